// File: rtl/instr_entry_if.sv
// Instruction-memory write port: request/data/address from the entry block, ack from memory.
interface instr_entry_if #(
    parameter int ADDR_W = 6
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (output mem_we, mem_addr, mem_wdata, input mem_ack);
    modport slave  (input mem_we, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/instr_entry.sv
// Nibble-at-a-time instruction word editor with write/ack commit into instruction memory.
// Buttons are synchronized and edge-detected here; debounce is done upstream on the board.
module instr_entry #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           sw,
    input  logic                 btn_right,
    input  logic                 btn_left,
    input  logic                 btn_center,
    input  logic                 btn_down,
    instr_entry_if.master        mem,
    output logic [31:0]          word,
    output logic [2:0]           cursor,
    output logic [3:0]           disp_nibble,
    output logic                 full
);
    typedef enum logic [1:0] {S_EDIT, S_WRITE, S_FULL} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    // Button bit order: 3=down, 2=center, 1=right, 0=left (also descending priority).
    logic [3:0] raw, sync1, sync2, prev, pulse;
    state_t     state;

    assign raw   = {btn_down, btn_center, btn_right, btn_left};
    assign pulse = sync2 & ~prev;

    assign mem.mem_wdata = word;
    assign disp_nibble   = word[{cursor, 2'b00} +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1        <= '0;
            sync2        <= '0;
            prev         <= '0;
            state        <= S_EDIT;
            word         <= '0;
            cursor       <= '0;
            full         <= 1'b0;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            prev  <= sync2;
            case (state)
                S_WRITE: begin
                    // Pulses arriving here are dropped; word and cursor are kept for the next edit.
                    if (mem.mem_ack) begin
                        mem.mem_we <= 1'b0;
                        if (mem.mem_addr == LAST_ADDR) begin
                            state <= S_FULL;
                            full  <= 1'b1;
                        end else begin
                            mem.mem_addr <= mem.mem_addr + 1'b1;
                            state        <= S_EDIT;
                        end
                    end
                end
                default: begin
                    // EDIT and FULL share the editing path; only EDIT honours down.
                    if (pulse[3] && state == S_EDIT) begin
                        state      <= S_WRITE;
                        mem.mem_we <= 1'b1;
                    end else if (pulse[2]) begin
                        word[{cursor, 2'b00} +: 4] <= sw;
                    end else if (pulse[1]) begin
                        if (cursor != 3'd7) cursor <= cursor + 3'd1;
                    end else if (pulse[0]) begin
                        if (cursor != 3'd0) cursor <= cursor - 3'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_entry.sv
// Directed bench for instr_entry at DEPTH=4: editing, handshake timing, priority, full and held buttons.
module tb_instr_entry;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sw = '0;
    logic        btn_right = 1'b0, btn_left = 1'b0, btn_center = 1'b0, btn_down = 1'b0;
    logic [31:0] word;
    logic [2:0]  cursor;
    logic [3:0]  disp_nibble;
    logic        full;

    instr_entry_if #(.ADDR_W(ADDR_W)) mem_if ();

    instr_entry #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .sw(sw),
        .btn_right(btn_right), .btn_left(btn_left),
        .btn_center(btn_center), .btn_down(btn_down),
        .mem(mem_if), .word(word), .cursor(cursor),
        .disp_nibble(disp_nibble), .full(full)
    );

    always #5 clk = ~clk;

    localparam logic [3:0] B_DOWN = 4'b1000, B_CENTER = 4'b0100, B_RIGHT = 4'b0010, B_LEFT = 4'b0001;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: counts cycles with mem_we high, logs accepted writes, flags addr/data drift.
    int          we_cycles = 0;
    int          wr_n = 0;
    int          unstable = 0;
    logic [31:0] wr_a [16];
    logic [31:0] wr_d [16];
    logic        prev_we = 1'b0;
    logic [31:0] prev_a = '0, prev_d = '0;

    always @(negedge clk) begin
        if (mem_if.mem_we) begin
            we_cycles++;
            if (prev_we && (32'(mem_if.mem_addr) != prev_a || mem_if.mem_wdata != prev_d)) unstable++;
            if (mem_if.mem_ack && wr_n < 16) begin
                wr_a[wr_n] = 32'(mem_if.mem_addr);
                wr_d[wr_n] = mem_if.mem_wdata;
                wr_n++;
            end
        end
        prev_we = mem_if.mem_we;
        prev_a  = 32'(mem_if.mem_addr);
        prev_d  = mem_if.mem_wdata;
    end

    task automatic set_btns(input logic [3:0] b);
        btn_down = b[3]; btn_center = b[2]; btn_right = b[1]; btn_left = b[0];
    endtask

    // One-cycle raw press, no waiting for the effect.
    task automatic pulse_btn(input logic [3:0] b);
        @(negedge clk); set_btns(b);
        @(negedge clk); set_btns(4'b0);
    endtask

    // Press, release and wait until the effect (and a tied-ack write) has completed.
    task automatic press(input logic [3:0] b);
        pulse_btn(b);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_we(input string tag);
        int k = 0;
        while (!mem_if.mem_we && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk(tag, 32'(mem_if.mem_we), 32'd1);
    endtask

    int base_we, base_wr;

    initial begin
        mem_if.mem_ack = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_word", word, 32'h0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst_we", 32'(mem_if.mem_we), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_disp", 32'(disp_nibble), 32'd0);

        // Reset mid-WRITE drops mem_we without a clock edge.
        pulse_btn(B_DOWN);
        wait_we("midrst_we_rise");
        #2 rst = 1'b1;
        #1 chk("midrst_we_async", 32'(mem_if.mem_we), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("midrst_addr", 32'(mem_if.mem_addr), 32'd0);

        // Nibble entry and cursor saturation.
        sw = 4'h3; press(B_CENTER);
        press(B_RIGHT);
        sw = 4'hA; press(B_CENTER);
        repeat (6) press(B_RIGHT);
        sw = 4'hF; press(B_CENTER);
        press(B_RIGHT);
        chk("entry_word", word, 32'hF00000A3);
        chk("entry_cursor_sat7", 32'(cursor), 32'd7);
        chk("entry_disp", 32'(disp_nibble), 32'hF);
        repeat (8) press(B_LEFT);
        chk("left_cursor_sat0", 32'(cursor), 32'd0);
        chk("left_disp", 32'(disp_nibble), 32'h3);

        // Tied ack: single-cycle write to address 0.
        mem_if.mem_ack = 1'b1;
        base_we = we_cycles; base_wr = wr_n;
        press(B_DOWN);
        chk("tied_we_cycles", 32'(we_cycles - base_we), 32'd1);
        chk("tied_wr_count", 32'(wr_n - base_wr), 32'd1);
        chk("tied_wr_addr", wr_a[0], 32'd0);
        chk("tied_wr_data", wr_d[0], 32'hF00000A3);
        chk("tied_addr_after", 32'(mem_if.mem_addr), 32'd1);

        // Ack delayed 3 cycles with buttons pressed during the wait.
        mem_if.mem_ack = 1'b0;
        base_we = we_cycles; base_wr = wr_n;
        pulse_btn(B_DOWN);
        wait_we("dly_we_rise");
        sw = 4'h5; set_btns(B_CENTER);
        @(negedge clk); set_btns(B_RIGHT);
        @(negedge clk); set_btns(4'b0);
        @(negedge clk); mem_if.mem_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("dly_we_cycles", 32'(we_cycles - base_we), 32'd4);
        chk("dly_wr_addr", wr_a[1], 32'd1);
        chk("dly_wr_data", wr_d[1], 32'hF00000A3);
        chk("dly_word_kept", word, 32'hF00000A3);
        chk("dly_cursor_kept", 32'(cursor), 32'd0);
        chk("dly_addr_after", 32'(mem_if.mem_addr), 32'd2);

        // Same-cycle pulses: down beats center, center beats right.
        sw = 4'h9;
        pulse_btn(B_DOWN | B_CENTER);
        repeat (4) @(negedge clk);
        chk("sim_dc_wr_addr", wr_a[2], 32'd2);
        chk("sim_dc_word", word, 32'hF00000A3);
        chk("sim_dc_addr_after", 32'(mem_if.mem_addr), 32'd3);
        sw = 4'h7;
        press(B_CENTER | B_RIGHT);
        chk("sim_cr_word", word, 32'hF00000A7);
        chk("sim_cr_cursor", 32'(cursor), 32'd0);

        // Last address: enters FULL, further commits ignored, editing still works.
        press(B_DOWN);
        chk("full_wr_addr", wr_a[3], 32'd3);
        chk("full_wr_data", wr_d[3], 32'hF00000A7);
        chk("full_flag", 32'(full), 32'd1);
        chk("full_addr_held", 32'(mem_if.mem_addr), 32'd3);
        base_we = we_cycles;
        press(B_DOWN);
        repeat (3) @(negedge clk);
        chk("full_no_we", 32'(we_cycles - base_we), 32'd0);
        chk("full_still", 32'(full), 32'd1);
        sw = 4'hC;
        press(B_CENTER);
        chk("full_edit_word", word, 32'hF00000AC);
        chk("stable_addr_data", 32'(unstable), 32'd0);

        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("rst2_full", 32'(full), 32'd0);
        chk("rst2_addr", 32'(mem_if.mem_addr), 32'd0);
        chk("rst2_word", word, 32'h0);

        // Held right: one step, visible two edges after first sampling.
        @(negedge clk); btn_right = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("held_after_e1", 32'(cursor), 32'd0);
        @(negedge clk);
        chk("held_after_e2", 32'(cursor), 32'd1);
        repeat (47) @(negedge clk);
        btn_right = 1'b0;
        repeat (4) @(negedge clk);
        chk("held_single_step", 32'(cursor), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
